memory_bus_bridge: RTL

MEMORY_BUS_BRIDGE -- requirements
Module: memory_bus_bridge

---
 rtl/memory_bus_bridge.sv | 114 +++++++++++
 1 files changed

// File: rtl/memory_bus_bridge.sv
// memory_bus_bridge: CPU word bus to block RAM plus debug I/O (LEDs, synchronised buttons); unmapped accesses pulse busError
module memory_bus_bridge #(
  parameter int ADDRESS_SIZE = 16,
  parameter int RAM_ADDRESS_SIZE = 11,
  parameter logic [ADDRESS_SIZE-1:0] IO_BASE = 16'hFF00
)(
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        strobe,
  input  logic                        writeEnable,
  input  logic [ADDRESS_SIZE-1:0]     address,
  input  logic [31:0]                 dataWrite,
  output logic                        ready,
  output logic [31:0]                 dataRead,
  output logic                        ramEnable,
  output logic                        ramWriteEnable,
  output logic [RAM_ADDRESS_SIZE-1:0] ramAddress,
  output logic [31:0]                 ramDataWrite,
  input  logic [31:0]                 ramDataRead,
  input  logic                        btnA,
  input  logic                        btnB,
  output logic [7:0]                  bits,
  output logic                        red,
  output logic                        green,
  output logic                        blue,
  output logic                        busError
);
  typedef enum logic [1:0] {IDLE, RAM_ACCESS, RAM_WAIT, DONE} state_t;
  state_t state, state_n;
  logic we_q, we_n, ready_n, ram_en_n, ram_we_n, bus_err_n;
  logic [31:0] data_read_n, ram_wdata_n, io_rdata;
  logic [RAM_ADDRESS_SIZE-1:0] ram_addr_n;
  logic [10:0] led, led_n;
  logic [1:0] btn_meta, btn_sync;
  logic ram_hit, io_hit, unused_addr;
  assign ram_hit = address[ADDRESS_SIZE-1:RAM_ADDRESS_SIZE+2] == '0;
  assign io_hit = address[ADDRESS_SIZE-1:8] == IO_BASE[ADDRESS_SIZE-1:8];
  assign io_rdata = address[7:2] == 6'd0 ? {21'd0, led} : address[7:2] == 6'd1 ? {30'd0, btn_sync} : 32'd0;
  assign {blue, green, red, bits} = led;
  assign unused_addr = ^address[1:0];
  always_comb begin
    state_n = state;
    we_n = we_q;
    ready_n = ready;
    data_read_n = dataRead;
    ram_en_n = 1'b0;
    ram_we_n = 1'b0;
    ram_addr_n = ramAddress;
    ram_wdata_n = ramDataWrite;
    bus_err_n = 1'b0;
    led_n = led;
    case (state)
      IDLE: if (strobe) begin
        we_n = writeEnable;
        if (ram_hit) begin
          ram_en_n = 1'b1;
          ram_we_n = writeEnable;
          ram_addr_n = address[RAM_ADDRESS_SIZE+1:2];
          ram_wdata_n = dataWrite;
          state_n = RAM_ACCESS;
        end else begin
          ready_n = 1'b1;
          data_read_n = io_hit && !writeEnable ? io_rdata : 32'd0;
          bus_err_n = !io_hit;
          led_n = io_hit && writeEnable && address[7:2] == 6'd0 ? dataWrite[10:0] : led;
          state_n = DONE;
        end
      end
      RAM_ACCESS: begin
        ready_n = we_q;
        data_read_n = we_q ? 32'd0 : dataRead;
        state_n = we_q ? DONE : RAM_WAIT;
      end
      RAM_WAIT: begin
        ready_n = 1'b1;
        data_read_n = ramDataRead;
        state_n = DONE;
      end
      DONE: if (!strobe) begin
        ready_n = 1'b0;
        state_n = IDLE;
      end
    endcase
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      we_q <= 1'b0;
      ready <= 1'b0;
      dataRead <= '0;
      ramEnable <= 1'b0;
      ramWriteEnable <= 1'b0;
      ramAddress <= '0;
      ramDataWrite <= '0;
      busError <= 1'b0;
      led <= '0;
      btn_meta <= '0;
      btn_sync <= '0;
    end else begin
      state <= state_n;
      we_q <= we_n;
      ready <= ready_n;
      dataRead <= data_read_n;
      ramEnable <= ram_en_n;
      ramWriteEnable <= ram_we_n;
      ramAddress <= ram_addr_n;
      ramDataWrite <= ram_wdata_n;
      busError <= bus_err_n;
      led <= led_n;
      btn_meta <= {btnB, btnA};
      btn_sync <= btn_meta;
    end
  end
endmodule
